// File: rtl/mycpu_if_pkg.sv
// mycpu_if_pkg: shared definitions for the instruction fetch stage.
//   if_state_e       - fetch FSM state encoding
//   RESET_PC_DEFAULT - default address of the first fetch after reset
//   NOP              - instruction word presented while nothing is valid
package mycpu_if_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } if_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/mycpu_if_skid.sv
// mycpu_if_skid: one-entry skid buffer holding a fetched word and its pc.
//   clk, rst           - clock, asynchronous active-low reset
//   push, push_data,
//   push_pc            - load a new entry (wins over pop in the same cycle)
//   pop                - entry moved out this cycle
//   flush              - drop the entry (wins over everything)
//   valid, data, pc    - buffered entry
module mycpu_if_skid
    import mycpu_if_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic [31:0] push_pc,
    input  logic        pop,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= NOP;
            pc    <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= push_data;
            pc    <= push_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mycpu_if.sv
// mycpu_if: instruction fetch stage with a single outstanding memory request.
//   clk, rst                 - clock, asynchronous active-low reset
//   inst_req, inst_addr      - fetch request / word-aligned address
//   inst_gnt                 - memory accepts the request this cycle
//   inst_rvalid, inst_rdata  - returned instruction
//   id_allowin               - decode consumes the presented instruction
//   if_valid, instruction,
//   if_pc                    - instruction presented to decode
//   br_taken, br_target      - single-cycle redirect from a later stage
module mycpu_if
    import mycpu_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] if_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        discard_q, discard_d;
    logic        out_valid_q;
    logic [31:0] out_data_q, out_pc_q;

    logic        skid_valid;
    logic [31:0] skid_data, skid_pc;
    logic        skid_push, skid_pop;

    logic grant, resp, accept, consume;

    // New requests are held off while the skid buffer is full, so a returning
    // word always has somewhere to land.
    always_comb begin
        state_d  = state_q;
        inst_req = 1'b0;
        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                inst_req = !skid_valid;
                if (inst_req && inst_gnt) state_d = StWait;
            end
            StWait: if (inst_rvalid) state_d = StReq;
            default: state_d = StIdle;
        endcase
    end

    assign grant   = inst_req & inst_gnt;
    assign resp    = (state_q == StWait) & inst_rvalid;
    assign accept  = resp & ~discard_q & ~br_taken;
    assign consume = out_valid_q & id_allowin;

    // A redirect poisons whatever response is still in flight after this cycle.
    always_comb begin
        discard_d = discard_q;
        if (resp) discard_d = 1'b0;
        if (br_taken && (((state_q == StWait) && !inst_rvalid) || grant)) discard_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            req_pc_q  <= 32'h0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            if (br_taken) begin
                pc_q <= br_target & 32'hFFFF_FFFC;
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end
            if (grant) req_pc_q <= pc_q;
        end
    end

    // Output register: refilled from the skid buffer first so order is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= NOP;
            out_pc_q    <= 32'h0;
        end else if (br_taken) begin
            out_valid_q <= 1'b0;
        end else if (consume) begin
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= skid_data;
                out_pc_q    <= skid_pc;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= inst_rdata;
                out_pc_q    <= req_pc_q;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (!out_valid_q && accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= inst_rdata;
            out_pc_q    <= req_pc_q;
        end
    end

    assign skid_pop  = consume & skid_valid;
    assign skid_push = accept & out_valid_q & ~(consume & ~skid_valid);

    mycpu_if_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (skid_push),
        .push_data (inst_rdata),
        .push_pc   (req_pc_q),
        .pop       (skid_pop),
        .flush     (br_taken),
        .valid     (skid_valid),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    assign inst_addr   = pc_q;
    assign if_valid    = out_valid_q;
    assign instruction = out_data_q;
    assign if_pc       = out_pc_q;

endmodule

// File: tb/tb_mycpu_if.sv
// tb_mycpu_if: directed bench for mycpu_if with a memory model and a
// scoreboard of words expected to reach decode, in order.
module tb_mycpu_if;
    import mycpu_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt = 1'b0;
    logic        inst_rvalid = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        id_allowin = 1'b0;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] if_pc;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;

    always #5 clk = ~clk;

    mycpu_if dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_gnt    (inst_gnt),
        .inst_rvalid (inst_rvalid),
        .inst_rdata  (inst_rdata),
        .id_allowin  (id_allowin),
        .if_valid    (if_valid),
        .instruction (instruction),
        .if_pc       (if_pc),
        .br_taken    (br_taken),
        .br_target   (br_target)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // memory / transaction model
    bit          outst = 0;
    bit          kill  = 0;
    int          cnt   = 0;
    logic [31:0] oaddr = 32'h0;

    // stimulus controls
    bit          allow_v = 1, gnt_en = 1, br_v = 0, br_on_gnt = 0, br_on_rv = 0, force_rv = 0;
    int          lat = 0;
    logic [31:0] tgt = 32'h0;

    // values sampled at the negedge of the last tick
    bit          s_valid, s_gnt, s_req;
    logic [31:0] s_gaddr, s_pc;
    int          held_max = 0;
    int          n_cons = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        bit   stale;
        @(negedge clk);
        stale       = 0;
        id_allowin  = allow_v;
        br_taken    = br_v;
        br_v        = 0;
        br_target   = tgt;
        inst_gnt    = inst_req & gnt_en;
        inst_rvalid = 1'b0;
        inst_rdata  = 32'h0;
        if (force_rv) begin
            inst_rvalid = 1'b1;
            inst_rdata  = 32'hDEAD_BEEF;
            force_rv    = 0;
            stale       = 1;
        end else if (outst && cnt == 0) begin
            inst_rvalid = 1'b1;
            inst_rdata  = mem_word(oaddr);
        end else if (outst) begin
            cnt--;
        end
        if (br_on_gnt && inst_gnt) begin
            br_taken  = 1'b1;
            br_on_gnt = 0;
        end
        if (br_on_rv && inst_rvalid && !stale) begin
            br_taken = 1'b1;
            br_on_rv = 0;
        end
        s_valid = if_valid;
        s_pc    = if_pc;
        s_req   = inst_req;
        s_gnt   = inst_gnt;
        s_gaddr = inst_addr;
        if (inst_req) chk("single_outstanding", {31'b0, outst}, 32'd0);
        if (inst_gnt) chk("addr_align", {30'b0, inst_addr[1:0]}, 32'd0);
        if (if_valid && id_allowin) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_word observed_pc=%h expected=none", if_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("deliver_pc", if_pc, e.pc);
                chk("deliver_data", instruction, e.data);
            end
            n_cons++;
        end
        if (inst_rvalid && !stale) begin
            if (!kill && !br_taken) sb.push_back({oaddr, inst_rdata});
            outst = 0;
            kill  = 0;
        end
        if (br_taken) begin
            sb.delete();
            if (outst) kill = 1;
        end
        if (inst_gnt) begin
            outst = 1;
            oaddr = inst_addr;
            cnt   = lat;
            if (br_taken) kill = 1;
        end
        if (sb.size() > held_max) held_max = sb.size();
        @(posedge clk);
    endtask

    task automatic wait_gnt(input string tag, output logic [31:0] a);
        bit got = 0;
        a = 32'h0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_gnt) begin
                a   = s_gaddr;
                got = 1;
                break;
            end
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL %s_timeout observed=no_grant expected=grant", tag);
        end
    endtask

    task automatic wait_valid(input string tag);
        bit got = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (s_valid) begin
                got = 1;
                break;
            end
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL %s_timeout observed=no_valid expected=valid", tag);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          n, c0;
        bit          b;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instruction", instruction, NOP);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_inst_addr", inst_addr, 32'hBFC0_0000);
        rst = 1'b1;

        // zero-wait streaming
        wait_gnt("seq0", a);
        chk("seq0_addr", a, 32'hBFC0_0000);
        wait_gnt("seq1", a);
        chk("seq1_addr", a, 32'hBFC0_0004);
        wait_gnt("seq2", a);
        chk("seq2_addr", a, 32'hBFC0_0008);
        wait_valid("stream");
        for (int k = 1; k <= 6; k++) begin
            tick();
            b = (k % 2 == 0);
            chk("valid_alternate", {31'b0, s_valid}, {31'b0, b});
        end

        // decode stall: output + skid fill, then requests stop
        allow_v  = 0;
        held_max = 0;
        repeat (5) begin
            n = sb.size();
            tick();
            if (n == 2) chk("no_req_while_full", {31'b0, s_req}, 32'd0);
        end
        chk("stall_held", held_max, 32'd2);
        chk("stall_valid", {31'b0, if_valid}, 32'd1);
        allow_v = 1;
        c0 = n_cons;
        repeat (6) tick();
        b = (n_cons - c0 >= 2);
        chk("stall_release_delivered", {31'b0, b}, 32'd1);

        // redirect during WAIT, unaligned target
        lat = 2;
        wait_gnt("brw_pre", a);
        lat = 0;
        tgt = 32'h8000_0003;
        br_v = 1;
        tick();
        wait_gnt("brw", a);
        chk("br_wait_addr", a, 32'h8000_0000);
        wait_valid("brw_valid");
        chk("br_wait_if_pc", s_pc, 32'h8000_0000);

        // redirect coincident with grant
        tgt = 32'h0000_1000;
        br_on_gnt = 1;
        wait_gnt("brg_pre", a);
        wait_gnt("brg", a);
        chk("br_gnt_addr", a, 32'h0000_1000);
        wait_valid("brg_valid");
        chk("br_gnt_if_pc", s_pc, 32'h0000_1000);

        // redirect coincident with rvalid
        tgt = 32'h0000_2000;
        br_on_rv = 1;
        for (int i = 0; i < 20 && br_on_rv; i++) tick();
        chk("br_rv_fired", {31'b0, br_on_rv}, 32'd0);
        wait_gnt("brr", a);
        chk("br_rv_addr", a, 32'h0000_2000);
        wait_valid("brr_valid");
        chk("br_rv_if_pc", s_pc, 32'h0000_2000);

        // pc wrap
        tgt = 32'hFFFF_FFFC;
        br_v = 1;
        tick();
        wait_gnt("wrap0", a);
        chk("wrap_top_addr", a, 32'hFFFF_FFFC);
        wait_gnt("wrap1", a);
        chk("wrap_zero_addr", a, 32'h0000_0000);

        // reset in WAIT, then a stale response
        lat = 3;
        wait_gnt("rstw_pre", a);
        tick();
        @(negedge clk);
        rst         = 1'b0;
        inst_gnt    = 1'b0;
        inst_rvalid = 1'b0;
        br_taken    = 1'b0;
        outst       = 0;
        kill        = 0;
        sb.delete();
        lat         = 0;
        @(negedge clk);
        chk("rst2_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst2_inst_req", {31'b0, inst_req}, 32'd0);
        chk("rst2_inst_addr", inst_addr, 32'hBFC0_0000);
        rst    = 1'b1;
        gnt_en = 0;
        force_rv = 1;
        tick();
        chk("stale_valid0", {31'b0, s_valid}, 32'd0);
        force_rv = 1;
        tick();
        chk("stale_valid1", {31'b0, s_valid}, 32'd0);
        tick();
        chk("stale_valid2", {31'b0, s_valid}, 32'd0);
        chk("post_rst_req", {31'b0, s_req}, 32'd1);
        chk("post_rst_addr", s_gaddr, 32'hBFC0_0000);
        gnt_en = 1;
        wait_gnt("post_rst", a);
        chk("post_rst_gnt_addr", a, 32'hBFC0_0000);
        wait_valid("post_rst_valid");
        chk("post_rst_if_pc", s_pc, 32'hBFC0_0000);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
